// File: rtl/key_event_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_event_pkg: shared state encoding, reset constants and counter sizing   |
// | for the pushbutton event detector.                     Revision: 1.0       |
// +----------------------------------------------------------------------------+
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    DEB_PRESS   = 2'b01,
    HELD        = 2'b10,
    DEB_RELEASE = 2'b11
  } key_state_e;

  localparam logic       SYNC_RESET_VALUE  = 1'b1;
  localparam logic [1:0] STATE_RESET_VALUE = IDLE;

  // Bits needed to hold 0..max_value inclusive, never less than one.
  function automatic int cnt_width(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_event_channel: one key's synchroniser, debounce FSM and hold/repeat    |
// | counters. Auto-repeat is built only with KEY_EVENT_REPEAT_EN. Revision: 1.0|
// +----------------------------------------------------------------------------+
module key_event_channel
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int REPEAT_CYCLES     = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  localparam logic [1:0] ST_IDLE        = IDLE;
  localparam logic [1:0] ST_DEB_PRESS   = DEB_PRESS;
  localparam logic [1:0] ST_HELD        = HELD;
  localparam logic [1:0] ST_DEB_RELEASE = DEB_RELEASE;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  logic [1:0]        sync_d, sync_q;
  logic [1:0]        state_d, state_q;
  logic [DEB_W-1:0]  deb_d, deb_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  logic              key_level_d, key_level_q;
  logic              press_d, press_q;
  logic              release_d, release_q;
  logic              long_d, long_q;
  logic              event_press;
  logic              repeat_fire;
  logic              synced;

  assign sync_d = {sync_q[0], key_n};
  assign synced = sync_q[1];

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    event_press = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!synced) begin
          state_d = ST_DEB_PRESS;
          deb_d   = DEB_W'(1);
        end
      end
      ST_DEB_PRESS: begin
        if (synced) begin
          state_d = ST_IDLE;
        end else if (deb_q == DEB_MAX) begin
          state_d     = ST_HELD;
          event_press = 1'b1;
          hold_d      = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (synced) begin
          state_d = ST_DEB_RELEASE;
          deb_d   = DEB_W'(1);
        end else if (hold_q != HOLD_MAX) begin
          // Saturation at HOLD_MAX is what keeps long_pulse to once per hold.
          hold_d = hold_q + 1'b1;
          long_d = (hold_d == HOLD_MAX);
        end
      end
      ST_DEB_RELEASE: begin
        if (!synced) begin
          state_d = ST_HELD;
        end else if (deb_q == DEB_MAX) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        deb_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

`ifdef KEY_EVENT_REPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES);

  logic [REP_W-1:0] rep_d, rep_q;

  // Counts only once the hold has saturated, so the first repeat lands
  // REPEAT_CYCLES after long_pulse; DEB_RELEASE simply holds the value.
  always_comb begin
    rep_d       = rep_q;
    repeat_fire = 1'b0;
    if ((state_q == ST_HELD) && !synced && (hold_q == HOLD_MAX)) begin
      if (rep_q == REP_MAX - 1'b1) begin
        rep_d       = '0;
        repeat_fire = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end else if (state_d == ST_IDLE) begin
      rep_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign press_d     = event_press | repeat_fire;
  assign key_level_d = (state_d == ST_HELD) || (state_d == ST_DEB_RELEASE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q      <= {2{SYNC_RESET_VALUE}};
      state_q     <= STATE_RESET_VALUE;
      deb_q       <= '0;
      hold_q      <= '0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule
`default_nettype wire

// File: rtl/key_event_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_event_detector: NUM_KEYS independent debounced pushbutton channels.    |
// | Define KEY_EVENT_REPEAT_EN to build auto-repeat.        Revision: 1.0       |
// +----------------------------------------------------------------------------+
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int REPEAT_CYCLES     = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse
);

  if ((NUM_KEYS < 1) || (NUM_KEYS > 16)) begin : g_bad_num_keys
    $error("NUM_KEYS must be within 1..16");
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_channel
    key_event_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .key_n        (key_n[k]),
      .key_level    (key_level[k]),
      .press_pulse  (press_pulse[k]),
      .release_pulse(release_pulse[k]),
      .long_pulse   (long_pulse[k])
    );
  end

endmodule
`default_nettype wire
